// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH-entry register file, two async read ports with WB bypass,
// single write port, $zero hardwired, post-reset clear sweep one entry per cycle.
module reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  init_busy
);
  typedef enum logic {INIT, READY} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= ADDR_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep ends on the edge that clears the last entry; entry 0 is never stored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      state_d = &cnt_q ? READY : INIT;
      cnt_d   = &cnt_q ? '0 : cnt_q + ADDR_WIDTH'(1);
    end
  end

  assign init_busy = (state_q == INIT);
  assign mem_we    = !rst && (init_busy || (write_en && write_addr != '0));
  assign mem_wa    = init_busy ? cnt_q : write_addr;
  assign mem_wd    = init_busy ? '0 : write_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign read_data_1 = (init_busy || !read_en_1 || read_addr_1 == '0) ? '0 :
                       (write_en && write_addr == read_addr_1) ? write_data : mem_q[read_addr_1];
  assign read_data_2 = (init_busy || !read_en_2 || read_addr_2 == '0) ? '0 :
                       (write_en && write_addr == read_addr_2) ? write_data : mem_q[read_addr_2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file against an independent behavioural model.
module tb_reg_file;
  logic        clk = 0;
  logic        rst;
  logic        read_en_1, read_en_2, write_en;
  logic [4:0]  read_addr_1, read_addr_2, write_addr;
  logic [31:0] read_data_1, read_data_2, write_data;
  logic        init_busy;

  reg_file #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2), .read_data_2(read_data_2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic busy; logic [31:0] rd1; logic [31:0] rd2; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] m_mem [32];
  int          sweep_left;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
    if (sweep_left > 0 || !en || a == 0) return 32'h0;
    if (write_en && write_addr == a) return write_data;
    return m_mem[a];
  endfunction

  task automatic cyc(input logic r, input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e, o;
    @(negedge clk);
    rst = r; read_en_1 = e1; read_addr_1 = a1; read_en_2 = e2; read_addr_2 = a2;
    write_en = we; write_addr = wa; write_data = wd;
    e.busy = sweep_left > 0;
    e.rd1  = m_read(e1, a1);
    e.rd2  = m_read(e2, a2);
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    check("busy", {31'b0, init_busy}, {31'b0, o.busy});
    check("rd1", read_data_1, o.rd1);
    check("rd2", read_data_2, o.rd2);
    @(posedge clk);
    if (r) sweep_left = 31;
    else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0) for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else if (we && wa != 0) m_mem[wa] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 5'd3, 1, 5'd3, 0, 5'd0, 32'h0);
  endtask

  task automatic read_all;
    for (int i = 1; i < 32; i++) cyc(0, 1, 5'(i), 1, 5'(32 - i), 0, 5'd0, 32'h0);
  endtask

  initial begin
    rst = 1; read_en_1 = 0; read_en_2 = 0; write_en = 0;
    read_addr_1 = 0; read_addr_2 = 0; write_addr = 0; write_data = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    sweep_left = 31;
    @(posedge clk);
    cyc(1, 1, 5'd1, 1, 5'd2, 1, 5'd1, 32'hAAAA5555);
    cyc(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0);
    // sweep with a suppressed write to r3, then reset at sweep cycle 10
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 5'd3, 1, 5'd3, i == 5, 5'd3, 32'h12345678);
    cyc(1, 1, 5'd3, 1, 5'd3, 1, 5'd3, 32'h12345678);
    idle(33);
    read_all();
    cyc(0, 1, 5'd5, 1, 5'd5, 1, 5'd5, 32'hDEADBEEF);
    cyc(0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 32'h0);
    cyc(0, 0, 5'd5, 1, 5'd5, 0, 5'd0, 32'h0);
    cyc(0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h11111111);
    cyc(0, 1, 5'd7, 1, 5'd7, 1, 5'd7, 32'h22222222);
    cyc(0, 1, 5'd7, 1, 5'd7, 0, 5'd0, 32'h0);
    cyc(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 32'hFFFFFFFF);
    cyc(0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++)
      cyc(0, 1, 5'(i), 1, 5'(i - 1), 1, 5'(i), {$urandom_range(255, 1), 24'(i)});
    read_all();
    cyc(1, 1, 5'd9, 1, 5'd9, 1, 5'd9, 32'hCAFEF00D);
    idle(32);
    read_all();
    for (int i = 0; i < 300; i++)
      cyc(i % 97 == 96, 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), 5'($urandom), $urandom);
    idle(32);
    read_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
